branch_cond_unit: RTL

- Registered branch-condition evaluator for the CPU control path, and the successor to the combinational flag tester.
- Holds NUM_BANKS banked ZCSO flag registers (bank 0 for normal context, bank 1 for interrupt context) with per-flag update masks.
- Evaluates a 4-bit condition code against the flags and a true/false polarity bit.
- Returns a registered taken/not-taken decision through a valid/ack handshake to the PC-select logic.

---
 rtl/bcu_pkg.sv | 28 ++
 rtl/bcu_cond_eval.sv | 48 ++++
 rtl/branch_cond_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bcu_pkg.sv
// Shared types for the branch condition unit.
// Condition codes, flag positions and FSM states.
package bcu_pkg;

  typedef enum logic [3:0] {
    COND_TRUE        = 4'b0000,
    COND_OVF         = 4'b0011,
    COND_NEG         = 4'b0100,
    COND_ZERO        = 4'b0101,
    COND_CARRY       = 4'b0110,
    COND_NEG_OR_ZERO = 4'b0111,
    COND_SLT         = 4'b1000,
    COND_SLE         = 4'b1001,
    COND_JMP_EN      = 4'b1100,
    COND_JMP_DIS     = 4'b1111
  } cond_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;

  typedef enum logic {
    IDLE,
    RESULT
  } fsm_e;

endpackage

// File: rtl/bcu_cond_eval.sv
// Combinational condition decoder.
// Maps a condition code and polarity onto taken/err.
module bcu_cond_eval
  import bcu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  input  logic       polarity,
  output logic       taken,
  output logic       err
);

  logic fz, fc, fn, fo;
  logic mz, mc, mn, mo;
  logic mlt, mle;

  assign fz = flags[FLAG_Z];
  assign fc = flags[FLAG_C];
  assign fn = flags[FLAG_N];
  assign fo = flags[FLAG_O];

  assign mz  = ~(polarity ^ fz);
  assign mc  = ~(polarity ^ fc);
  assign mn  = ~(polarity ^ fn);
  assign mo  = ~(polarity ^ fo);
  assign mlt = ~(polarity ^ (fn ^ fo));
  assign mle = ~(polarity ^ ((fn ^ fo) | fz));

  // Decode the condition; unknown codes flag an error.
  always_comb begin
    taken = 1'b0;
    err   = 1'b0;
    unique case (cond)
      COND_TRUE:        taken = polarity;
      COND_OVF:         taken = mo;
      COND_NEG:         taken = mn;
      COND_ZERO:        taken = mz;
      COND_CARRY:       taken = mc;
      COND_NEG_OR_ZERO: taken = mn | mz;
      COND_SLT:         taken = mlt;
      COND_SLE:         taken = mle;
      COND_JMP_EN:      taken = 1'b1;
      COND_JMP_DIS:     taken = 1'b0;
      default:          err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch-condition evaluator.
// Banked ZCSO flags, forwarding, valid/ack result.
module branch_cond_unit
  import bcu_pkg::*;
#(
  parameter  int NUM_FLAGS = 4,
  parameter  int NUM_BANKS = 2,
  parameter  int COND_W    = 4,
  localparam int BANK_W    =
    (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flag_we,
  input  logic [NUM_FLAGS-1:0] flag_mask,
  input  logic [NUM_FLAGS-1:0] flag_in,
  input  logic [BANK_W-1:0]    flag_bank,
  input  logic [BANK_W-1:0]    cur_bank,
  input  logic                 save_restore,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [COND_W-1:0]    cond,
  input  logic                 polarity,
  output logic                 res_valid,
  output logic                 res_taken,
  output logic                 res_err,
  input  logic                 res_ack,
  output logic [NUM_FLAGS-1:0] flags_out
);

  logic [NUM_FLAGS-1:0] bank_q   [NUM_BANKS];
  logic [NUM_FLAGS-1:0] bank_nxt [NUM_BANKS];
  logic [NUM_FLAGS-1:0] cur_val;
  logic [NUM_FLAGS-1:0] eff;
  logic                 cur_ok;
  logic                 fb_ok;
  logic                 bank_err;
  logic                 ev_taken;
  logic                 ev_err;
  logic                 capture;
  fsm_e                 state_q;
  fsm_e                 state_d;

  assign cur_ok   = 32'(cur_bank) < NUM_BANKS;
  assign fb_ok    = 32'(flag_bank) < NUM_BANKS;
  assign bank_err = ~cur_ok | ~fb_ok;

  // Read the evaluation bank; out-of-range reads as zero.
  always_comb begin
    cur_val = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (cur_bank == BANK_W'(b))
        cur_val = bank_q[b];
  end

  // Merge a same-cycle masked write into the evaluated flags.
  always_comb begin
    eff = cur_val;
    if (flag_we && cur_ok && flag_bank == cur_bank)
      eff = (cur_val & ~flag_mask) | (flag_in & flag_mask);
  end

  // Next bank contents: copy first, masked update on top.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_nxt[b] = bank_q[b];
      if (flag_bank == BANK_W'(b)) begin
        if (save_restore)
          bank_nxt[b] = cur_val;
        if (flag_we)
          bank_nxt[b] = (bank_nxt[b] & ~flag_mask)
                      | (flag_in & flag_mask);
      end
    end
  end

  // Flag bank registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        bank_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        bank_q[b] <= bank_nxt[b];
    end
  end

  bcu_cond_eval u_eval (
    .flags    (eff[3:0]),
    .cond     (cond),
    .polarity (polarity),
    .taken    (ev_taken),
    .err      (ev_err)
  );

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, ready and capture strobe.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b1;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        req_ready = res_ack;
        if (res_ack) begin
          if (req_valid) capture = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decision registers, loaded only on an accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_taken <= 1'b0;
      res_err   <= 1'b0;
    end else if (capture) begin
      res_taken <= ev_taken & ~bank_err;
      res_err   <= ev_err | bank_err;
    end
  end

  assign res_valid = (state_q == RESULT);
  assign flags_out = cur_val;

endmodule
